arbiter_rr_weighted: RTL

Registered, parametrised weighted round-robin arbiter. It is the successor of the existing round-robin arbiter for DMA/TLP source selection in the PCIe application layer. It supports any port count from 2 to 32. Grants are held for a programmable number of transfers, ended by an explicit end-of-transfer strobe, so requesters no longer need to drop request for a cycle. Re-arbitration happens back-to-back with no idle bubble.

---
 rtl/arbiter_rr_weighted.sv | 130 +++++++++++++
 1 files changed

// File: rtl/arbiter_rr_weighted.sv
// Weighted round-robin arbiter, registered one-hot grant; per-port quanta from iWEIGHT when ARB_WEIGHT_EN is defined.
// Latency: a request seen in IDLE, or a release, gives the next registered grant one cycle later with no bubble.
// Backpressure: none; a grant is held until iLAST exhausts the quantum or the owner drops its request.
module arbiter_rr_weighted #(
    parameter  int WIDTH  = 8,
    parameter  int WCNT_W = 4,
    localparam int IDX_W  = $clog2(WIDTH)
) (
    input  logic                    iCLK,
    input  logic                    iRST,
    input  logic [WIDTH-1:0]        iREQ,
    input  logic [WIDTH*WCNT_W-1:0] iWEIGHT,
    input  logic                    iLAST,
    output logic [WIDTH-1:0]        oGNT,
    output logic [IDX_W-1:0]        oGNT_IDX,
    output logic                    oGNT_VLD
);

    if (WIDTH < 2 || WIDTH > 32) begin : gBadWidth
        $error("arbiter_rr_weighted: WIDTH must be in 2..32");
    end

    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

    localparam logic [2*WIDTH-1:0] ONE2 = {{(2*WIDTH-1){1'b0}}, 1'b1};

    state_t              state, stateNext;
    logic [WIDTH-1:0]    base, baseNext, arbBase, rotGnt, winGnt, gntNext;
    logic [IDX_W-1:0]    winIdx, idxNext;
    logic                vldNext, ownerReq, lastRel, relGnt, loadGnt, anyReq;
    logic [2*WIDTH-1:0]  reqDbl, maskedDbl, pickDbl;

    assign anyReq   = |iREQ;
    assign ownerReq = |(iREQ & oGNT);
    assign rotGnt   = {oGNT[WIDTH-2:0], oGNT[WIDTH-1]};

`ifdef ARB_WEIGHT_EN
    logic [WCNT_W-1:0] qcnt, qcntNext, winWeight;
    assign lastRel = iLAST && (qcnt == WCNT_W'(1));
`else
    logic unusedWeight;
    assign unusedWeight = ^iWEIGHT;
    assign lastRel      = iLAST;
`endif

    // Request withdrawal releases regardless of iLAST.
    assign relGnt  = (state == GRANT) && (!ownerReq || lastRel);
    assign loadGnt = (state == IDLE) || relGnt;
    assign arbBase = relGnt ? rotGnt : base;

    // Duplicated request vector: lowest set bit at or above base handles wrap-around.
    assign reqDbl    = {iREQ, iREQ};
    assign maskedDbl = reqDbl & ~({{WIDTH{1'b0}}, arbBase} - ONE2);
    assign pickDbl   = maskedDbl & (~maskedDbl + ONE2);
    assign winGnt    = pickDbl[WIDTH-1:0] | pickDbl[2*WIDTH-1:WIDTH];

    always_comb begin
        winIdx = '0;
`ifdef ARB_WEIGHT_EN
        winWeight = '0;
`endif
        for (int i = 0; i < WIDTH; i++) begin
            if (winGnt[i]) begin
                winIdx = IDX_W'(i);
`ifdef ARB_WEIGHT_EN
                winWeight = iWEIGHT[i*WCNT_W +: WCNT_W];
`endif
            end
        end
    end

    // State register (all flops, including registered outputs).
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state    <= IDLE;
            base     <= {{(WIDTH-1){1'b0}}, 1'b1};
            oGNT     <= '0;
            oGNT_IDX <= '0;
            oGNT_VLD <= 1'b0;
`ifdef ARB_WEIGHT_EN
            qcnt     <= '0;
`endif
        end else begin
            state    <= stateNext;
            base     <= baseNext;
            oGNT     <= gntNext;
            oGNT_IDX <= idxNext;
            oGNT_VLD <= vldNext;
`ifdef ARB_WEIGHT_EN
            qcnt     <= qcntNext;
`endif
        end
    end

    // Next-state logic.
    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (anyReq) stateNext = GRANT;
            GRANT:   if (relGnt && !anyReq) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Output / datapath logic.
    always_comb begin
        baseNext = base;
        gntNext  = oGNT;
        idxNext  = oGNT_IDX;
        vldNext  = oGNT_VLD;
`ifdef ARB_WEIGHT_EN
        qcntNext = qcnt;
`endif
        if (relGnt) baseNext = rotGnt;
        if (loadGnt) begin
            gntNext = winGnt;
            idxNext = winIdx;
            vldNext = anyReq;
`ifdef ARB_WEIGHT_EN
            if (!anyReq)
                qcntNext = '0;
            else
                qcntNext = (winWeight == '0) ? WCNT_W'(1) : winWeight;
        end else if (iLAST) begin
            qcntNext = qcnt - WCNT_W'(1);
`endif
        end
    end

endmodule
